// File: rtl/mul_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// mul_issue_queue_pkg
//   Shared types for the M-extension multiply dispatch path.
//   - mul_ops_e      : multiply operation selector (shared with the multiplier)
//   - fu_state_e     : functional-unit busy/free status (shared with the multiplier)
//   - mul_iq_state_e : issue-queue control FSM states
//   - mul_iq_entry_s : one buffered multiply op {rs1, rs2, op, rd}
//   The entry struct is sized from MUL_XLEN / MUL_REG_W, so the top-level
//   XLEN / REG_W parameters are expected to keep their default values.
// -----------------------------------------------------------------------------
package mul_issue_queue_pkg;

  localparam int MUL_XLEN  = 32;
  localparam int MUL_REG_W = 5;

  typedef enum logic [1:0] {
    MUL_,
    MULH_,
    MULHSU_,
    MULHU_
  } mul_ops_e;

  typedef enum logic {
    FREE,
    BUSY
  } fu_state_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } mul_iq_state_e;

  typedef struct packed {
    logic [MUL_XLEN-1:0]  rs1;
    logic [MUL_XLEN-1:0]  rs2;
    mul_ops_e             op;
    logic [MUL_REG_W-1:0] rd;
  } mul_iq_entry_s;

  // Any product with a zero operand is zero regardless of signedness or
  // which half is requested.
  function automatic logic has_zero_operand(input mul_iq_entry_s entry);
    return (entry.rs1 == '0) || (entry.rs2 == '0);
  endfunction

endpackage

// File: rtl/mul_iq_fifo.sv
// -----------------------------------------------------------------------------
// mul_iq_fifo
//   Synchronous FIFO of mul_iq_entry_s with a combinational head view.
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset
//     push_i         write push_data_i (ignored when full)
//     push_data_i    entry to enqueue
//     pop_i          drop the head entry (ignored when empty)
//     head_o         current head entry (valid while !empty_o)
//     full_o         occupancy == DEPTH
//     empty_o        occupancy == 0
//     count_o        occupancy, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module mul_iq_fifo
  import mul_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  mul_iq_entry_s          push_data_i,
  input  logic                   pop_i,
  output mul_iq_entry_s          head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  mul_iq_entry_s    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they
  // were written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/mul_issue_queue.sv
// -----------------------------------------------------------------------------
// mul_issue_queue
//   Dispatch stage in front of the iterative multiply unit. Buffers decoded
//   multiply ops, issues one at a time by gating the multiplier clock enable,
//   holds the operands steady while it iterates, captures the result and
//   offers it to writeback over a valid/ready handshake.
//   Ports:
//     clk_i, rst_i             clock, synchronous active-high reset
//     in_valid_i/in_ready_o    decode handshake (ready = queue not full)
//     in_rs1_i, in_rs2_i       operands of the offered op
//     in_op_i, in_rd_i         operation and destination register
//     mul_multiplier_o         -> multiplier multiplier_i
//     mul_multiplicand_o       -> multiplier multiplicand_i
//     mul_op_o                 -> multiplier operation_i
//     mul_clk_en_o             -> multiplier clk_en_i
//     mul_state_i              <- multiplier fu_state_o
//     mul_result_i             <- multiplier result_o
//     wb_valid_o/wb_ready_i    writeback handshake
//     wb_data_o, wb_rd_o       result and destination tag
//     count_o                  queue occupancy
//   Optional build macro:
//     MUL_ZERO_BYPASS_EN       ops with a zero operand skip the multiplier and
//                              go straight to writeback with a zero result.
// -----------------------------------------------------------------------------
module mul_issue_queue
  import mul_issue_queue_pkg::*;
#(
  parameter int XLEN  = MUL_XLEN,
  parameter int DEPTH = 4,
  parameter int REG_W = MUL_REG_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [XLEN-1:0]        in_rs1_i,
  input  logic [XLEN-1:0]        in_rs2_i,
  input  mul_ops_e               in_op_i,
  input  logic [REG_W-1:0]       in_rd_i,
  output logic [XLEN-1:0]        mul_multiplier_o,
  output logic [XLEN-1:0]        mul_multiplicand_o,
  output mul_ops_e               mul_op_o,
  output logic                   mul_clk_en_o,
  input  fu_state_e              mul_state_i,
  input  logic [XLEN-1:0]        mul_result_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [XLEN-1:0]        wb_data_o,
  output logic [REG_W-1:0]       wb_rd_o,
  output logic [$clog2(DEPTH):0] count_o
);

  mul_iq_entry_s    push_entry;
  mul_iq_entry_s    head_entry;
  mul_iq_entry_s    issue_q;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  mul_iq_state_e    state_q;
  mul_iq_state_e    state_d;
  logic             capture;
  logic             bypass;
  logic             wb_valid_q;
  logic [XLEN-1:0]  wb_data_q;
  logic [REG_W-1:0] wb_rd_q;

  assign push_entry = '{rs1: in_rs1_i, rs2: in_rs2_i, op: in_op_i, rd: in_rd_i};
  assign in_ready_o = ~fifo_full;
  assign fifo_push  = in_valid_i & ~fifo_full;

  mul_iq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_data_i(push_entry),
    .pop_i      (fifo_pop),
    .head_o     (head_entry),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (count_o)
  );

  // The issue register feeds the multiplier directly; its high-half mux reads
  // these combinationally, so they must not move until the result is captured.
  assign mul_multiplier_o   = issue_q.rs1;
  assign mul_multiplicand_o = issue_q.rs2;
  assign mul_op_o           = issue_q.op;

  assign wb_valid_o = wb_valid_q;
  assign wb_data_o  = wb_data_q;
  assign wb_rd_o    = wb_rd_q;

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, pop and clock-enable decode. A pop only happens from IDLE or
  // on a writeback handshake, so at most one op is ever in flight and nothing
  // issues while a result is still waiting to be consumed.
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    mul_clk_en_o = 1'b0;
    capture      = 1'b0;
    bypass       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
        end
      end
      ISSUE: begin
        mul_clk_en_o = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        // Clocking only while busy lets the multiplier counter wrap back to
        // zero and then hold there once it reports FREE.
        mul_clk_en_o = (mul_state_i == BUSY);
        if (mul_state_i == FREE) begin
          capture = 1'b1;
          state_d = WB;
        end
      end
      WB: begin
        if (wb_ready_i) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_pop) begin
`ifdef MUL_ZERO_BYPASS_EN
      if (has_zero_operand(head_entry)) begin
        bypass  = 1'b1;
        state_d = WB;
      end else begin
        state_d = ISSUE;
      end
`else
      state_d = ISSUE;
`endif
    end
  end

  // Issue and writeback registers. A bypassed op never touches the issue
  // register, so the multiplier inputs stay put while it is skipped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      if (fifo_pop && !bypass) begin
        issue_q <= head_entry;
      end
      if (capture) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= mul_result_i;
        wb_rd_q    <= issue_q.rd;
      end else if (bypass) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= '0;
        wb_rd_q    <= head_entry.rd;
      end else if ((state_q == WB) && wb_ready_i) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_mul_issue_queue
//   Directed bench for mul_issue_queue with a behavioural model of the
//   16-step iterative multiplier hanging off the mul_* ports.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_issue_queue;
  import mul_issue_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [XLEN-1:0]   in_rs1_i;
  logic [XLEN-1:0]   in_rs2_i;
  mul_ops_e          in_op_i;
  logic [REG_W-1:0]  in_rd_i;
  logic [XLEN-1:0]   mul_multiplier_o;
  logic [XLEN-1:0]   mul_multiplicand_o;
  mul_ops_e          mul_op_o;
  logic              mul_clk_en_o;
  fu_state_e         mul_state_i;
  logic [XLEN-1:0]   mul_result_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [XLEN-1:0]   wb_data_o;
  logic [REG_W-1:0]  wb_rd_o;
  logic [CNT_W-1:0]  count_o;

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  mul_issue_queue #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .REG_W(REG_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .in_rs1_i          (in_rs1_i),
    .in_rs2_i          (in_rs2_i),
    .in_op_i           (in_op_i),
    .in_rd_i           (in_rd_i),
    .mul_multiplier_o  (mul_multiplier_o),
    .mul_multiplicand_o(mul_multiplicand_o),
    .mul_op_o          (mul_op_o),
    .mul_clk_en_o      (mul_clk_en_o),
    .mul_state_i       (mul_state_i),
    .mul_result_i      (mul_result_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_data_o         (wb_data_o),
    .wb_rd_o           (wb_rd_o),
    .count_o           (count_o)
  );

  // Multiplier model: operands latched on the first enabled edge, counter
  // steps 1..16 while enabled and wraps to 0, FREE whenever the counter is 0.
  // It shares the queue's reset, as the real unit does through rst_n = ~rst.
  logic [4:0]      mulCnt = '0;
  logic [XLEN-1:0] mulA   = '0;
  logic [XLEN-1:0] mulB   = '0;
  mul_ops_e        mulOp  = MUL_;

  function automatic logic [31:0] mulRef(input logic [31:0] a, input logic [31:0] b,
                                         input mul_ops_e op);
    logic [63:0] ss;
    logic [63:0] uu;
    logic [63:0] su;
    ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    uu = {32'b0, a} * {32'b0, b};
    su = {{32{a[31]}}, a} * {32'b0, b};
    case (op)
      MUL_:    return uu[31:0];
      MULH_:   return ss[63:32];
      MULHSU_: return su[63:32];
      default: return uu[63:32];
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      mulCnt <= '0;
    end else if (mul_clk_en_o) begin
      if (mulCnt == 5'd0) begin
        mulA  <= mul_multiplier_o;
        mulB  <= mul_multiplicand_o;
        mulOp <= mul_op_o;
      end
      mulCnt <= (mulCnt == 5'd16) ? 5'd0 : mulCnt + 5'd1;
    end
  end

  assign mul_state_i  = (mulCnt != 5'd0) ? BUSY : FREE;
  assign mul_result_i = mulRef(mulA, mulB, mulOp);

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] rs1,
                               input logic [31:0] rs2, input mul_ops_e op,
                               input logic [4:0] rd);
    in_valid_i = valid;
    in_rs1_i   = rs1;
    in_rs2_i   = rs2;
    in_op_i    = op;
    in_rd_i    = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Starts in the ISSUE cycle T of an op and ends in cycle T+18 with the
  // result presented; operands must hold from T through the capture at T+17.
  task automatic runOp(input string tag, input logic [31:0] rs1, input logic [31:0] rs2,
                       input mul_ops_e op, input logic [31:0] expData,
                       input logic [4:0] expRd);
    for (int k = 0; k < 18; k++) begin
      checkOutput($sformatf("%s operands T+%0d", tag, k),
                  {mul_op_o, mul_multiplier_o, mul_multiplicand_o}, {op, rs1, rs2});
      checkOutput($sformatf("%s clk_en/valid T+%0d", tag, k),
                  {mul_clk_en_o, wb_valid_o}, {(k <= 16), 1'b0});
      tick();
    end
    checkOutput($sformatf("%s result T+18", tag),
                {wb_valid_o, wb_rd_o, wb_data_o, mul_clk_en_o},
                {1'b1, expRd, expData, 1'b0});
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b0, '0, '0, MUL_, '0);
    wb_ready_i = 1'b1;
    rst_i = 1'b1;
    tick(2);
    checkOutput("reset count", count_o, 3'd0);
    checkOutput("reset ready", in_ready_o, 1'b1);
    checkOutput("reset ctrl", {wb_valid_o, mul_clk_en_o}, 2'b00);
    checkOutput("reset data", {wb_data_o, wb_rd_o, mul_multiplier_o, mul_multiplicand_o},
                {32'd0, 5'd0, 32'd0, 32'd0});
    rst_i = 1'b0;
    tick();

    // Single op: 7 * 6 -> 42 on x3
    applyStimulus(1'b1, 32'd7, 32'd6, MUL_, 5'd3);
    tick();
    checkOutput("single count after push", count_o, 3'd1);
    applyStimulus(1'b0, '0, '0, MUL_, '0);
    tick();
    runOp("single", 32'd7, 32'd6, MUL_, 32'd42, 5'd3);
    tick();
    checkOutput("single drained", {wb_valid_o, mul_clk_en_o, count_o}, {1'b0, 1'b0, 3'd0});

    // Fill with writeback stalled: op0 issues, four more fill the queue
    wb_ready_i = 1'b0;
    applyStimulus(1'b1, 32'd3, 32'd4, MUL_, 5'd1);
    checkOutput("fill ready op0", in_ready_o, 1'b1);
    tick();
    checkOutput("fill count A1", count_o, 3'd1);
    applyStimulus(1'b1, 32'd5, 32'd5, MUL_, 5'd2);
    tick();
    checkOutput("fill count at issue", {count_o, mul_clk_en_o}, {3'd1, 1'b1});
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU_, 5'd4);
    tick();
    checkOutput("fill count A3", count_o, 3'd2);
    applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0002, MULH_, 5'd5);
    tick();
    checkOutput("fill count A4", count_o, 3'd3);
    applyStimulus(1'b1, 32'hFFFF_FFFE, 32'hC000_0000, MULHSU_, 5'd6);
    checkOutput("fill ready op4", in_ready_o, 1'b1);
    tick();
    checkOutput("fill full", {count_o, in_ready_o}, {3'd4, 1'b0});
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, MUL_, 5'd31);
    tick();
    checkOutput("fill full hold 1", {count_o, in_ready_o}, {3'd4, 1'b0});
    tick();
    checkOutput("fill full hold 2", {count_o, in_ready_o}, {3'd4, 1'b0});
    applyStimulus(1'b0, '0, '0, MUL_, '0);
    tick(13);
    checkOutput("op0 result", {wb_valid_o, wb_rd_o, wb_data_o, mul_clk_en_o},
                {1'b1, 5'd1, 32'd12, 1'b0});

    // Backpressure: result and tag frozen, multiplier idle, nothing issued
    for (int i = 1; i <= 40; i++) begin
      tick();
      checkOutput($sformatf("backpressure cycle %0d", i),
                  {wb_valid_o, wb_rd_o, wb_data_o, mul_clk_en_o, count_o},
                  {1'b1, 5'd1, 32'd12, 1'b0, 3'd4});
    end
    wb_ready_i = 1'b1;
    tick();
    checkOutput("release issue", {mul_clk_en_o, wb_valid_o, count_o}, {1'b1, 1'b0, 3'd3});
    runOp("op1", 32'd5, 32'd5, MUL_, 32'd25, 5'd2);
    tick();
    runOp("op2 mulhu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU_, 32'hFFFF_FFFE, 5'd4);
    tick();
    runOp("op3 mulh", 32'h8000_0000, 32'h0000_0002, MULH_, 32'hFFFF_FFFF, 5'd5);
    tick();
    runOp("op4 mulhsu", 32'hFFFF_FFFE, 32'hC000_0000, MULHSU_, 32'hFFFF_FFFE, 5'd6);
    tick();
    checkOutput("fill drained", {wb_valid_o, mul_clk_en_o, count_o}, {1'b0, 1'b0, 3'd0});

    // Reset in the middle of an op with another op queued
    applyStimulus(1'b1, 32'd9, 32'd9, MUL_, 5'd7);
    tick();
    applyStimulus(1'b1, 32'd2, 32'd2, MUL_, 5'd10);
    tick();
    applyStimulus(1'b0, '0, '0, MUL_, '0);
    checkOutput("rst op issue", mul_clk_en_o, 1'b1);
    tick(8);
    checkOutput("rst op T+8", {mul_clk_en_o, count_o}, {1'b1, 3'd1});
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("after reset ctrl", {count_o, wb_valid_o, mul_clk_en_o}, {3'd0, 1'b0, 1'b0});
    checkOutput("after reset data", {wb_data_o, wb_rd_o, mul_multiplier_o},
                {32'd0, 5'd0, 32'd0});
    for (int i = 1; i <= 20; i++) begin
      tick();
      checkOutput($sformatf("abandoned op quiet %0d", i),
                  {wb_valid_o, mul_clk_en_o, count_o}, {1'b0, 1'b0, 3'd0});
    end
    applyStimulus(1'b1, 32'd3, 32'd5, MUL_, 5'd8);
    tick();
    applyStimulus(1'b0, '0, '0, MUL_, '0);
    tick();
    runOp("post reset", 32'd3, 32'd5, MUL_, 32'd15, 5'd8);
    tick();
    checkOutput("post reset drained", {wb_valid_o, count_o}, {1'b0, 3'd0});

    // Zero operand op
    applyStimulus(1'b1, 32'd0, 32'h0000_1234, MUL_, 5'd9);
    tick();
    applyStimulus(1'b0, '0, '0, MUL_, '0);
    checkOutput("zero op pop cycle", {mul_clk_en_o, wb_valid_o}, 2'b00);
    tick();
`ifdef MUL_ZERO_BYPASS_EN
    checkOutput("zero bypass result", {wb_valid_o, wb_rd_o, wb_data_o, mul_clk_en_o},
                {1'b1, 5'd9, 32'd0, 1'b0});
    tick();
    checkOutput("zero bypass drained", {wb_valid_o, mul_clk_en_o, count_o},
                {1'b0, 1'b0, 3'd0});
`else
    runOp("zero op", 32'd0, 32'h0000_1234, MUL_, 32'd0, 5'd9);
    tick();
    checkOutput("zero op drained", {wb_valid_o, mul_clk_en_o, count_o},
                {1'b0, 1'b0, 3'd0});
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
